// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, reset PC, NOP encoding,
// instruction-memory depth and the IF/ID register payload.
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam int          IM_DEPTH_DEFAULT = 1024;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc4;
        logic              exc;
    } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls from D, the instruction
// memory address/data pair, and the IF/ID register outputs toward decode.
// master = the fetch stage, slave = its environment (D stage + IM).
interface if_stage_if;
    import mips_pkg::*;

    logic              stall_f;
    logic              flush_d;
    logic              redirect_v;
    logic [WORD_W-1:0] redirect_pc;
    logic [WORD_W-1:0] pc_f;
    logic [WORD_W-1:0] instr_f;
    logic [WORD_W-1:0] instr_d;
    logic [WORD_W-1:0] pc_d;
    logic [WORD_W-1:0] pc4_d;
    logic              exc_adel_d;

    modport master (
        input  stall_f, flush_d, redirect_v, redirect_pc, instr_f,
        output pc_f, instr_d, pc_d, pc4_d, exc_adel_d
    );

    modport slave (
        output stall_f, flush_d, redirect_v, redirect_pc, instr_f,
        input  pc_f, instr_d, pc_d, pc4_d, exc_adel_d
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: clear-to-NOP on flush (flush beats stall so a
// bubble is still inserted while the PC holds), hold on stall, else load.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t load_val,
    output if_id_t q
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Next IF/ID contents: a flushed entry keeps the current pc/pc4 but carries a NOP.
    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d       = load_val;
            if_id_d.instr = INSTR_NOP;
            if_id_d.exc   = 1'b0;
        end else if (!stall) begin
            if_id_d = load_val;
        end
    end

    // Register with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= '0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign q = if_id_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection (stall > redirect
// > pc+4) and the IF/ID register feeding decode. Redirects keep MIPS
// delay-slot behaviour: the word fetched in the redirect cycle still loads.
// Optional macro FETCH_EXC_EN adds fetch address-error detection
// (misaligned or outside the instruction memory window).
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_DEPTH = IM_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    if_stage_if.master   bus
);

    logic [WORD_W-1:0] pc_f_q;
    logic [WORD_W-1:0] pc_f_d;
    logic [WORD_W-1:0] pc_plus4;
    logic              fetch_err;
    if_id_t            load_val;
    if_id_t            if_id_out;

    // Modulo-2^32: 0xFFFF_FFFC simply wraps to 0.
    assign pc_plus4 = pc_f_q + 32'd4;
    assign bus.pc_f = pc_f_q;

`ifdef FETCH_EXC_EN
    // 33-bit limit so a window ending at 4 GiB cannot overflow the compare.
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_DEPTH);

    assign fetch_err = (pc_f_q[1:0] != 2'b00)
                    || (pc_f_q < PC_RESET)
                    || ({1'b0, pc_f_q} >= PC_LIMIT);
`else
    logic unused_im_depth;
    assign unused_im_depth = ^IM_DEPTH;
    assign fetch_err       = 1'b0;
`endif

    // Next-PC select: stall holds, a redirect target is taken unmasked, else sequential.
    always_comb begin
        pc_f_d = pc_plus4;
        if (bus.stall_f) begin
            pc_f_d = pc_f_q;
        end else if (bus.redirect_v) begin
            pc_f_d = bus.redirect_pc;
        end
    end

    // PC register with synchronous reset to the boot address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q <= PC_RESET;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    // Payload offered to IF/ID; a faulting fetch is replaced by a NOP but keeps its pc.
    always_comb begin
        load_val.instr = fetch_err ? INSTR_NOP : bus.instr_f;
        load_val.pc    = pc_f_q;
        load_val.pc4   = pc_plus4;
        load_val.exc   = fetch_err;
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .stall    (bus.stall_f),
        .flush    (bus.flush_d),
        .load_val (load_val),
        .q        (if_id_out)
    );

    assign bus.instr_d    = if_id_out.instr;
    assign bus.pc_d       = if_id_out.pc;
    assign bus.pc4_d      = if_id_out.pc4;
    assign bus.exc_adel_d = if_id_out.exc;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed fetch/redirect/stall/flush/reset
// scenarios followed by randomized control traffic, all compared against a
// cycle-level reference model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] W_A    = 32'hAAAA_0001;
    localparam logic [31:0] W_B    = 32'hBBBB_0002;
    localparam logic [31:0] W_C    = 32'hCCCC_0003;
    localparam logic [31:0] W_D    = 32'hDDDD_0004;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    if_stage_if ifc ();

    if_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [1024];
    assign ifc.instr_f = imem[ifc.pc_f[11:2]];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_exc;
    bit          m_known = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] pc);
`ifdef FETCH_EXC_EN
        longint unsigned a = longint'(pc);
        return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4 * 1024);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive controls, check fetch address, advance model, check IF/ID.
    task automatic step(input logic rst, input logic st, input logic fl,
                        input logic rv, input logic [31:0] rpc);
        logic [31:0] word;
        logic        err;
        @(negedge clk);
        reset           = rst;
        ifc.stall_f     = st;
        ifc.flush_d     = fl;
        ifc.redirect_v  = rv;
        ifc.redirect_pc = rpc;
        #1;
        if (m_known) check("pc_f", ifc.pc_f, m_pc);
        if (rst) begin
            m_pc    = RST_PC;
            m_instr = 32'h0;
            m_pcd   = 32'h0;
            m_pc4   = 32'h0;
            m_exc   = 1'b0;
            m_known = 1;
        end else begin
            word = imem[(m_pc / 4) % 1024];
            err  = addr_err(m_pc);
            if (fl) begin
                m_instr = 32'h0;
                m_pcd   = m_pc;
                m_pc4   = m_pc + 32'd4;
                m_exc   = 1'b0;
            end else if (!st) begin
                m_instr = err ? 32'h0 : word;
                m_pcd   = m_pc;
                m_pc4   = m_pc + 32'd4;
                m_exc   = err;
            end
            if (!st) m_pc = rv ? rpc : m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check("pc_f_post", ifc.pc_f, m_pc);
        check("instr_d", ifc.instr_d, m_instr);
        check("pc_d", ifc.pc_d, m_pcd);
        check("pc4_d", ifc.pc4_d, m_pc4);
        check("exc_adel_d", {31'h0, ifc.exc_adel_d}, {31'h0, m_exc});
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc;
        logic        r_rst, r_st, r_fl, r_rv;

        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        imem[0] = W_A;
        imem[1] = W_B;
        imem[2] = W_C;
        imem[3] = W_D;

        ifc.stall_f     = 1'b0;
        ifc.flush_d     = 1'b0;
        ifc.redirect_v  = 1'b0;
        ifc.redirect_pc = 32'h0;

        // 1: reset then sequential fetch
        step(1, 0, 0, 0, 32'h0);
        check("t1_reset_pc", ifc.pc_f, 32'h0000_3000);
        check("t1_reset_instr", ifc.instr_d, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("t1_instr_A", ifc.instr_d, W_A);
        check("t1_pc_3004", ifc.pc_f, 32'h0000_3004);
        step(0, 0, 0, 0, 32'h0);
        check("t1_instr_B", ifc.instr_d, W_B);

        // 2: redirect at pc=3008, delay slot kept
        step(0, 0, 0, 1, 32'h0000_3040);
        check("t2_delay_slot", ifc.instr_d, W_C);
        check("t2_target_pc", ifc.pc_f, 32'h0000_3040);
        step(0, 0, 0, 0, 32'h0);
        check("t2_target_instr", ifc.instr_d, imem[16]);

        // 3: two-cycle stall at pc=3010
        step(0, 0, 0, 1, 32'h0000_3010);
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        check("t3_hold_pc", ifc.pc_f, 32'h0000_3010);
        step(0, 0, 0, 0, 32'h0);
        check("t3_resume_pc", ifc.pc_f, 32'h0000_3014);
        check("t3_resume_pcd", ifc.pc_d, 32'h0000_3010);

        // 4: stall + flush at pc=3020
        step(0, 0, 0, 1, 32'h0000_3020);
        step(0, 1, 1, 0, 32'h0);
        check("t4_bubble_instr", ifc.instr_d, 32'h0);
        check("t4_bubble_pcd", ifc.pc_d, 32'h0000_3020);
        check("t4_hold_pc", ifc.pc_f, 32'h0000_3020);
        step(0, 0, 0, 0, 32'h0);
        check("t4_reload", ifc.instr_d, imem[8]);

        // stall + redirect: redirect dropped, then re-presented
        step(0, 1, 0, 1, 32'h0000_3100);
        step(0, 0, 0, 1, 32'h0000_3100);

        // 5: reset during stall with redirect
        step(1, 1, 0, 1, 32'h0000_3200);
        check("t5_reset_pc", ifc.pc_f, 32'h0000_3000);
        check("t5_reset_pcd", ifc.pc_d, 32'h0);

        // 6: address errors (misaligned, beyond window)
        step(0, 0, 0, 1, 32'h0000_3002);
        step(0, 0, 0, 1, 32'h0000_4000);
`ifdef FETCH_EXC_EN
        check("t6_misalign_exc", {31'h0, ifc.exc_adel_d}, 32'h1);
        check("t6_misalign_nop", ifc.instr_d, 32'h0);
`else
        check("t6_misalign_exc", {31'h0, ifc.exc_adel_d}, 32'h0);
`endif
        step(0, 0, 0, 0, 32'h0);
`ifdef FETCH_EXC_EN
        check("t6_range_exc", {31'h0, ifc.exc_adel_d}, 32'h1);
        check("t6_range_pcd", ifc.pc_d, 32'h0000_4000);
`else
        check("t6_range_exc", {31'h0, ifc.exc_adel_d}, 32'h0);
`endif

        // 32-bit wrap of the sequential PC
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0);
        check("wrap_pc", ifc.pc_f, 32'h0);
        check("wrap_pc4", ifc.pc4_d, 32'h0);
        free_run(2);

        // randomized control traffic
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_fl  = ($urandom_range(0, 5) == 0);
            r_rv  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) rpc = $urandom;
            else rpc = RST_PC + 32'(4 * $urandom_range(0, 1023));
            step(r_rst, r_st, r_fl, r_rv, rpc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
